// File: rtl/bit8_adder_sync_pkg.sv
// Common datapath package for the registered ripple-carry adder.
// Holds the default operand width so that instantiating blocks can share it.
package bit8_adder_sync_pkg;

  localparam int ADDER_WIDTH = 8;

endpackage : bit8_adder_sync_pkg

// File: rtl/bit8_adder_sync_full_adder.sv
// One-bit full adder cell, purely combinational.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit      (a ^ b ^ ci)
//   co   : carry out    (majority of a, b, ci)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/bit8_adder_sync.sv
// Registered WIDTH-bit ripple-carry adder with carry-in.
// Computes a + b + cin as unsigned values; the result is WIDTH+1 bits wide,
// so it can never overflow. One cycle of latency, no enable.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (clears sum and cout)
//   a, b : WIDTH-bit unsigned operands
//   cin  : carry-in, weight 2^0
//   sum  : registered a + b + cin, bit WIDTH is the final carry
//   cout : registered final carry, always equal to sum[WIDTH]
module bit8_adder_sync
  import bit8_adder_sync_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum,
  output logic             cout
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_chk
    $error("bit8_adder_sync: WIDTH must be in 1..64");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_bits;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s_bits[i]),
      .co (carry[i+1])
    );
  end

  // ---- stage p0: result register ----
  logic [WIDTH:0] sum_p0;
  logic           cout_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p0  <= '0;
      cout_p0 <= 1'b0;
    end else begin
      sum_p0  <= {carry[WIDTH], s_bits};
      cout_p0 <= carry[WIDTH];
    end
  end

  assign sum  = sum_p0;
  assign cout = cout_p0;

endmodule : bit8_adder_sync

// File: tb/tb_bit8_adder_sync.sv
// Self-checking bench for bit8_adder_sync: directed vectors on the default
// 8-bit instance, plus a random sweep across 8-, 1- and 16-bit instances.
module tb_bit8_adder_sync;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  a8, b8;
  logic        c8;
  logic [8:0]  sum8;
  logic        cout8;

  logic [0:0]  a1, b1;
  logic        c1;
  logic [1:0]  sum1;
  logic        cout1;

  logic [15:0] a16, b16;
  logic        c16;
  logic [16:0] sum16;
  logic        cout16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit8_adder_sync dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8), .sum(sum8), .cout(cout8)
  );

  bit8_adder_sync #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .sum(sum1), .cout(cout1)
  );

  bit8_adder_sync #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16), .sum(sum16), .cout(cout16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive8(input logic r, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    rst = r;
    a8  = av;
    b8  = bv;
    c8  = cv;
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [8:0] es, input logic ec);
    chk({tag, "_sum"}, 64'(sum8), 64'(es));
    chk({tag, "_cout"}, 64'(cout8), 64'(ec));
  endtask

  initial begin
    a1 = '0; b1 = '0; c1 = 1'b0;
    a16 = '0; b16 = '0; c16 = 1'b0;

    // Reset with all-ones inputs must still clear every output.
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
    tick();
    check8("reset", 9'h000, 1'b0);
    chk("reset_w1_sum", 64'(sum1), 64'h0);
    chk("reset_w1_cout", 64'(cout1), 64'h0);
    chk("reset_w16_sum", 64'(sum16), 64'h0);
    chk("reset_w16_cout", 64'(cout16), 64'h0);

    // First edge after release reflects inputs sampled at that edge.
    drive8(1'b0, 8'hFF, 8'hFF, 1'b1);
    tick();
    check8("release", 9'h1FF, 1'b1);
    chk("release_w1_sum", 64'(sum1), 64'h3);
    chk("release_w16_sum", 64'(sum16), 64'h1FFFF);

    drive8(1'b0, 8'h08, 8'h18, 1'b0);
    tick();
    check8("small", 9'h020, 1'b0);

    drive8(1'b0, 8'hFF, 8'hFF, 1'b0);
    tick();
    check8("max_nocin", 9'h1FE, 1'b1);

    drive8(1'b0, 8'hAA, 8'h55, 1'b1);
    tick();
    check8("ripple", 9'h100, 1'b1);

    // Back-to-back: each result lands exactly one edge after its inputs.
    drive8(1'b0, 8'h01, 8'h01, 1'b0);
    tick();
    check8("b2b_0", 9'h002, 1'b0);
    drive8(1'b0, 8'h80, 8'h80, 1'b0);
    tick();
    check8("b2b_1", 9'h100, 1'b1);

    // Mid-stream reset discards the add in flight.
    drive8(1'b0, 8'h03, 8'h04, 1'b0);
    tick();
    check8("pre_rst", 9'h007, 1'b0);
    drive8(1'b1, 8'h10, 8'h20, 1'b1);
    tick();
    check8("mid_rst", 9'h000, 1'b0);
    drive8(1'b0, 8'h10, 8'h20, 1'b1);
    tick();
    check8("post_rst", 9'h031, 1'b0);

    // Random sweep over all three widths.
    for (int i = 0; i < 1000; i++) begin
      logic [8:0]  e8;
      logic [1:0]  e1;
      logic [16:0] e16;
      a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
      a1  = 1'($urandom);  b1  = 1'($urandom);  c1  = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      e8  = 9'(a8) + 9'(b8) + 9'(c8);
      e1  = 2'(a1) + 2'(b1) + 2'(c1);
      e16 = 17'(a16) + 17'(b16) + 17'(c16);
      tick();
      chk("rnd_w8_sum", 64'(sum8), 64'(e8));
      chk("rnd_w8_cout", 64'(cout8), 64'(sum8[8]));
      chk("rnd_w1_sum", 64'(sum1), 64'(e1));
      chk("rnd_w1_cout", 64'(cout1), 64'(sum1[1]));
      chk("rnd_w16_sum", 64'(sum16), 64'(e16));
      chk("rnd_w16_cout", 64'(cout16), 64'(sum16[16]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_bit8_adder_sync
